// File: rtl/bundle_slot_sequencer.sv
// Fetch-side bundle sequencer: latches a 3-slot bundle, tracks pending slots, advances PC.
// Optional: define BUNDLE_TMPL_MASK_EN to mask fills with template bits [122:120].
module bundle_slot_sequencer #(
    parameter int                QSLOTS = 3,
    parameter int                AMSB   = 31,
    parameter logic [AMSB:0]     RSTPC  = 'hFFFC0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ihit,
    input  logic [127:0]      ibundle,
    input  logic [QSLOTS-1:0] queued,
    input  logic              branch_v,
    input  logic [AMSB:0]     branch_pc,
    output logic [AMSB:0]     pc,
    output logic              fetch_req,
    output logic [127:0]      bundle,
    output logic [QSLOTS-1:0] slotv,
    output logic              bundle_done,
    output logic [15:0]       miss_cnt
);

    typedef enum logic {FETCH, ISSUE} state_t;

    localparam logic [AMSB:0] PC_STEP = (AMSB+1)'(16);

    state_t            state;
    logic [QSLOTS-1:0] startmask;
    logic [QSLOTS-1:0] fillmask;
    logic [QSLOTS-1:0] rem;
    logic [QSLOTS-1:0] branch_start;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^branch_pc[1:0];
    assign fetch_req      = (state == FETCH);

    always_comb begin
        rem = slotv & ~queued;
`ifdef BUNDLE_TMPL_MASK_EN
        fillmask = startmask & ibundle[120 +: QSLOTS];
`else
        fillmask = startmask;
`endif
        // start slot 3 is illegal and behaves like slot 0
        case (branch_pc[3:2])
            2'd1:    branch_start = 3'b110;
            2'd2:    branch_start = 3'b100;
            default: branch_start = 3'b111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RSTPC;
            slotv       <= '0;
            bundle      <= '0;
            bundle_done <= 1'b0;
            miss_cnt    <= '0;
            startmask   <= '1;
        end else if (branch_v) begin
            state       <= FETCH;
            pc          <= {branch_pc[AMSB:4], 4'h0};
            slotv       <= '0;
            bundle_done <= 1'b0;
            startmask   <= branch_start;
        end else begin
            case (state)
                FETCH: begin
                    bundle_done <= 1'b0;
                    if (ihit) begin
                        bundle    <= ibundle;
                        slotv     <= fillmask;
                        startmask <= '1;
                        state     <= ISSUE;
                    end else if (miss_cnt != '1) begin
                        miss_cnt <= miss_cnt + 16'd1;
                    end
                end
                ISSUE: begin
                    slotv <= rem;
                    if (rem == '0) begin
                        pc          <= pc + PC_STEP;
                        bundle_done <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_bundle_slot_sequencer.sv
// Scoreboard bench for bundle_slot_sequencer: a reference model pushes expected outputs per cycle.
// Honours BUNDLE_TMPL_MASK_EN the same way as the design build.
module tb_bundle_slot_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         ihit;
    logic [127:0] ibundle;
    logic [2:0]   queued;
    logic         branch_v;
    logic [31:0]  branch_pc;
    logic [31:0]  pc;
    logic         fetch_req;
    logic [127:0] bundle;
    logic [2:0]   slotv;
    logic         bundle_done;
    logic [15:0]  miss_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bundle_slot_sequencer #(.QSLOTS(3), .AMSB(31), .RSTPC(32'hFFFC0100)) dut (
        .clk(clk), .rst(rst), .ihit(ihit), .ibundle(ibundle), .queued(queued),
        .branch_v(branch_v), .branch_pc(branch_pc), .pc(pc), .fetch_req(fetch_req),
        .bundle(bundle), .slotv(slotv), .bundle_done(bundle_done), .miss_cnt(miss_cnt)
    );

    typedef struct {
        logic [31:0]  pc;
        logic [2:0]   slotv;
        logic         done;
        logic [15:0]  miss;
        logic         freq;
        logic [127:0] bundle;
    } exp_t;

    exp_t sb[$];

    // reference model state
    logic         m_fetch;
    logic [31:0]  m_pc;
    logic [2:0]   m_slotv;
    logic [2:0]   m_start;
    logic         m_done;
    logic [15:0]  m_miss;
    logic [127:0] m_bundle;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic hit, input logic [127:0] ib,
                              input logic [2:0] q, input logic bv, input logic [31:0] bpc);
        logic [2:0] tmpl;
        logic [2:0] left;
        if (r) begin
            m_fetch = 1'b1; m_pc = 32'hFFFC0100; m_slotv = 3'b000; m_bundle = '0;
            m_done = 1'b0; m_miss = 16'd0; m_start = 3'b111;
        end else if (bv) begin
            m_fetch = 1'b1;
            m_pc    = bpc & 32'hFFFF_FFF0;
            m_slotv = 3'b000;
            m_done  = 1'b0;
            m_start = (bpc[3:2] == 2'd1) ? 3'b110 : (bpc[3:2] == 2'd2) ? 3'b100 : 3'b111;
        end else if (m_fetch) begin
            m_done = 1'b0;
            if (hit) begin
`ifdef BUNDLE_TMPL_MASK_EN
                tmpl = ib[122:120];
`else
                tmpl = 3'b111;
`endif
                m_bundle = ib;
                m_slotv  = m_start & tmpl;
                m_start  = 3'b111;
                m_fetch  = 1'b0;
            end else if (m_miss != 16'hFFFF) begin
                m_miss = m_miss + 16'd1;
            end
        end else begin
            left    = m_slotv & ~q;
            m_slotv = left;
            if (left == 3'b000) begin
                m_pc    = m_pc + 32'd16;
                m_done  = 1'b1;
                m_fetch = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic hit, input logic [127:0] ib,
                         input logic [2:0] q, input logic bv, input logic [31:0] bpc);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = r; ihit = hit; ibundle = ib; queued = q; branch_v = bv; branch_pc = bpc;
        model_step(r, hit, ib, q, bv, bpc);
        e.pc = m_pc; e.slotv = m_slotv; e.done = m_done; e.miss = m_miss;
        e.freq = m_fetch; e.bundle = m_bundle;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_eq("pc", pc, got.pc);
        check_eq("slotv", slotv, got.slotv);
        check_eq("bundle_done", bundle_done, got.done);
        check_eq("miss_cnt", miss_cnt, got.miss);
        check_eq("fetch_req", fetch_req, got.freq);
        check_eq("bundle", bundle, got.bundle);
    endtask

    logic [127:0] ones = '1;
    logic [127:0] t05;

    initial begin
        rst = 1'b1; ihit = 1'b0; ibundle = '0; queued = '0; branch_v = 1'b0; branch_pc = '0;
        t05 = {8'h05, 120'h0123456789ABCDEF0123456789ABCD};

        // reset state
        cycle(1, 0, '0, 3'b000, 0, 32'h0);
        check_eq("rst_pc", pc, 32'hFFFC0100);
        check_eq("rst_slotv", slotv, 3'b000);
        check_eq("rst_fetch_req", fetch_req, 1'b1);

        // basic fill and full accept
        cycle(0, 1, ones, 3'b000, 0, 32'h0);
        check_eq("tp1_slotv", slotv, 3'b111);
        check_eq("tp1_pc", pc, 32'hFFFC0100);
        cycle(0, 0, '0, 3'b111, 0, 32'h0);
        check_eq("tp1_done", bundle_done, 1'b1);
        check_eq("tp1_pc_next", pc, 32'hFFFC0110);
        check_eq("tp1_fetch_req", fetch_req, 1'b1);

        // partial queueing
        cycle(0, 1, ones, 3'b000, 0, 32'h0);
        cycle(0, 0, '0, 3'b001, 0, 32'h0);
        check_eq("part_110", slotv, 3'b110);
        cycle(0, 0, '0, 3'b011, 0, 32'h0);
        check_eq("part_100", slotv, 3'b100);
        check_eq("part_nodone", bundle_done, 1'b0);
        cycle(0, 0, '0, 3'b100, 0, 32'h0);
        check_eq("part_done", bundle_done, 1'b1);

        // miss counting
        cycle(1, 0, '0, 3'b000, 0, 32'h0);
        repeat (5) cycle(0, 0, ones, 3'b000, 0, 32'h0);
        check_eq("miss5", miss_cnt, 16'd5);
        cycle(0, 1, ones, 3'b000, 0, 32'h0);
        check_eq("miss_fill", slotv, 3'b111);

        // redirect mid-issue, queued ignored
        cycle(0, 0, '0, 3'b001, 0, 32'h0);
        cycle(0, 0, '0, 3'b110, 1, 32'h0000_2008);
        check_eq("br_pc", pc, 32'h0000_2000);
        check_eq("br_slotv", slotv, 3'b000);
        check_eq("br_nodone", bundle_done, 1'b0);
        cycle(0, 1, ones, 3'b000, 0, 32'h0);
        check_eq("br_fill", slotv, 3'b100);

        // template masking
        cycle(0, 0, '0, 3'b111, 0, 32'h0);
        cycle(0, 1, t05, 3'b000, 0, 32'h0);
`ifdef BUNDLE_TMPL_MASK_EN
        check_eq("tmpl_slotv", slotv, 3'b101);
`else
        check_eq("tmpl_slotv", slotv, 3'b111);
`endif
        cycle(0, 0, '0, 3'b111, 0, 32'h0);

        // empty-template bundle, and start-slot decodes 1 and 3
        cycle(0, 1, {8'h00, ones[119:0]}, 3'b000, 0, 32'h0);
        cycle(0, 0, '0, 3'b000, 0, 32'h0);
        cycle(0, 0, '0, 3'b000, 1, 32'h0000_3004);
        cycle(0, 1, ones, 3'b000, 0, 32'h0);
        check_eq("start1", slotv, 3'b110);
        cycle(0, 0, '0, 3'b000, 1, 32'h0000_400C);
        cycle(0, 1, ones, 3'b000, 0, 32'h0);
        check_eq("start3", slotv, 3'b111);

        // pc wrap, then reset beating branch
        cycle(0, 0, '0, 3'b000, 1, 32'hFFFF_FFF0);
        cycle(0, 1, ones, 3'b000, 0, 32'h0);
        cycle(0, 0, '0, 3'b111, 0, 32'h0);
        check_eq("wrap_pc", pc, 32'h0000_0000);
        cycle(1, 1, ones, 3'b111, 1, 32'h0000_5000);
        check_eq("rst_over_br", pc, 32'hFFFC0100);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  {$urandom, $urandom, $urandom, $urandom}, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
